// File: rtl/masked_and_driver_pkg.sv
// Shared constants, state encoding and LFSR step for the masked AND driver.
// The mask LFSR is a right-shifting Fibonacci register for x^16+x^14+x^13+x^11+1.
package masked_and_driver_pkg;

   localparam int D           = 2;
   localparam int AND_LATENCY = 3;
   localparam int LFSR_W      = 16;
   localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'h002D;
   localparam int FLUSH_TRIES = 4;

   typedef enum logic [2:0] {
      FLUSH   = 3'd0,
      IDLE    = 3'd1,
      LOAD    = 3'd2,
      RUN     = 3'd3,
      CAPTURE = 3'd4,
      DONE    = 3'd5
   } state_t;

   // Tap polynomial bits 16/14/13/11 map to state bits 0/2/3/5 after the right shift.
   function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
      return {^(s & LFSR_TAPS), s[LFSR_W-1:1]};
   endfunction

endpackage

// File: rtl/masked_and_driver_if.sv
// Host request/result signals plus the 2-share gadget handshake.
interface masked_and_driver_if
   import masked_and_driver_pkg::*;
#(
   parameter int N = 8
);
   logic           start;
   logic [N-1:0]   a;
   logic [N-1:0]   b;
   logic [N-1:0]   y;
   logic           busy;
   logic           done;
   logic           err;
   logic [0:D-1]   and_ina;
   logic [0:D-1]   and_inb;
   logic [0:0]     and_rin;
   logic           and_enable;
   logic           and_done;
   logic [0:D-1]   and_out;

   modport master (
      input  start, a, b, and_done, and_out,
      output y, busy, done, err, and_ina, and_inb, and_rin, and_enable
   );

   modport slave (
      output start, a, b, and_done, and_out,
      input  y, busy, done, err, and_ina, and_inb, and_rin, and_enable
   );
endinterface

// File: rtl/masked_and_driver_lfsr.sv
// Free-running 16-bit mask source; shifts every cycle regardless of driver state.
module mask_lfsr16
   import masked_and_driver_pkg::*;
#(
   parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
   input  logic              clk,
   input  logic              rst,
   output logic [LFSR_W-1:0] lfsr
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) lfsr <= SEED;
      else     lfsr <= lfsr_step(lfsr);
   end

endmodule

// File: rtl/masked_and_driver.sv
// Serial bit-by-bit driver for the 2-share masked AND gadget: masks operands,
// sequences the gadget handshake, recombines shares and realigns the gadget counter.
//
// state   | meaning
// FLUSH   | gadget counter unknown; enable until AndDone (ignoring the first cycle)
// IDLE    | waiting for start
// LOAD    | shares of the current bit held on the gadget inputs, enable low
// RUN     | enable high for the gadget latency
// CAPTURE | enable low, recombine output shares or flag a handshake error
// DONE    | one-cycle completion pulse
module masked_and_driver
   import masked_and_driver_pkg::*;
#(
   parameter int                N         = 8,
   parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
   input logic                 clk,
   input logic                 rst,
   masked_and_driver_if.master bus
);

   localparam int              IW           = (N > 1) ? $clog2(N) : 1;
   localparam logic [IW-1:0]   IDX_LAST     = IW'(N - 1);
   localparam logic [1:0]      RUN_LAST     = 2'(AND_LATENCY - 1);
   localparam logic [1:0]      FLUSH_RELOAD = 2'(FLUSH_TRIES - 1);

   state_t            state, state_nxt;
   logic [IW-1:0]     idx, load_idx;
   logic [1:0]        cyc;
   logic [1:0]        flush_cnt;
   logic              retry;
   logic [N-1:0]      a_q, b_q, y_q;
   logic [N-1:0]      a_src, b_src;
   logic              load_a, load_b;
   logic              err_q;
   logic              enable_q;
   logic [0:D-1]      ina_q, inb_q;
   logic [0:0]        rin_q;
   logic [LFSR_W-1:0] lfsr;
   logic              lfsr_unused;

   mask_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
      .clk  (clk),
      .rst  (rst),
      .lfsr (lfsr)
   );

   assign lfsr_unused = ^lfsr[LFSR_W-1:3];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= FLUSH;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      load_idx  = idx;
      a_src     = a_q;
      b_src     = b_q;
      case (state)
         FLUSH: begin
            // first enabled cycle may still show a stale AndDone level
            if (enable_q && (flush_cnt != FLUSH_RELOAD) && bus.and_done)
               state_nxt = retry ? LOAD : IDLE;
         end
         IDLE: begin
            a_src    = bus.a;
            b_src    = bus.b;
            load_idx = '0;
            if (bus.start) state_nxt = LOAD;
         end
         LOAD:    state_nxt = RUN;
         RUN:     if (cyc == RUN_LAST) state_nxt = CAPTURE;
         CAPTURE: begin
            load_idx = idx + 1'b1;
            if (!bus.and_done)        state_nxt = FLUSH;
            else if (idx == IDX_LAST) state_nxt = DONE;
            else                      state_nxt = LOAD;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = FLUSH;
      endcase
      load_a = a_src[load_idx];
      load_b = b_src[load_idx];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx       <= '0;
         cyc       <= '0;
         flush_cnt <= FLUSH_RELOAD;
         retry     <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         y_q       <= '0;
         err_q     <= 1'b0;
         enable_q  <= 1'b0;
         ina_q     <= '0;
         inb_q     <= '0;
         rin_q     <= '0;
      end else begin
         enable_q <= (state_nxt == FLUSH) || (state_nxt == RUN);
         // shares are registered on entry to LOAD and held through CAPTURE
         if (state_nxt == LOAD) begin
            ina_q <= {load_a ^ lfsr[0], lfsr[0]};
            inb_q <= {load_b ^ lfsr[1], lfsr[1]};
            rin_q <= lfsr[2];
            idx   <= load_idx;
            cyc   <= '0;
         end
         case (state)
            FLUSH: begin
               if (enable_q) begin
                  if (state_nxt != FLUSH) begin
                     retry     <= 1'b0;
                     flush_cnt <= FLUSH_RELOAD;
                  end else if (flush_cnt == '0) begin
                     err_q     <= 1'b1;
                     flush_cnt <= FLUSH_RELOAD;
                  end else begin
                     flush_cnt <= flush_cnt - 1'b1;
                  end
               end
            end
            IDLE: begin
               if (bus.start) begin
                  a_q <= bus.a;
                  b_q <= bus.b;
               end
            end
            RUN: cyc <= cyc + 1'b1;
            CAPTURE: begin
               if (bus.and_done) begin
                  y_q[idx] <= bus.and_out[0] ^ bus.and_out[1];
               end else begin
                  err_q <= 1'b1;
                  retry <= 1'b1;
                  ina_q <= '0;
                  inb_q <= '0;
                  rin_q <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.y          = y_q;
   assign bus.busy       = (state != IDLE);
   assign bus.done       = (state == DONE);
   assign bus.err        = err_q;
   assign bus.and_enable = enable_q;
   assign bus.and_ina    = ina_q;
   assign bus.and_inb    = inb_q;
   assign bus.and_rin    = rin_q;

endmodule

// File: doc/masked_and_driver.md
Name: masked_and_driver

Overview:
- Upstream controller for the 2-share masked AND gadget (AndEnable/AndDone handshake, 3-cycle enabled latency).
- Takes two unmasked N-bit operands and masks each bit into 2 shares using an internal LFSR.
- Issues one gadget operation per bit with fresh randomness, recombines the output shares and returns y = a & b.
- Also owns gadget counter realignment, because the gadget has no reset.

Parameters:
- N, 8, operand width in bits; processed serially, bit 0 first.
- LFSR_SEED, 16'hACE1, non-zero reset value of the 16-bit mask LFSR.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin operation; sampled only in IDLE
- a  in  N  operand A (unmasked), captured on accepted start
- b  in  N  operand B (unmasked), captured on accepted start
- y  out  N  result a&b; valid when done, held until next accepted start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when y is complete
- err  out  1  sticky: gadget handshake mismatch seen; cleared only by rst
- and_ina  out  [0:1]  shares of A bit to gadget (and_ina[0] = a_i ^ ma, and_ina[1] = ma)
- and_inb  out  [0:1]  shares of B bit (and_inb[0] = b_i ^ mb, and_inb[1] = mb)
- and_rin  out  [0:0]  refresh randomness r
- and_enable  out  1  gadget AndEnable
- and_done  in  1  gadget AndDone
- and_out  in  [0:1]  gadget output shares

Behaviour:
- Reset values: y=0, done=0, err=0, and_enable=0, and_ina/and_inb/and_rin=0, LFSR=LFSR_SEED, state=FLUSH, idx=0, cyc=0. busy=1 on leaving reset.
- LFSR: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, shifts every cycle. ma/mb/r = lfsr[0]/[1]/[2], sampled in LOAD only.
- All gadget inputs are registered and held constant from LOAD through CAPTURE.
- FLUSH (gadget counter state unknown):
  - and_enable=1, share inputs=0.
  - and_done is ignored in the first enabled cycle, since it may be a stale level.
  - From the 2nd enabled cycle on, and_done=1 → and_enable=0, go to IDLE. This leaves the gadget counter at 0.
  - If and_done is not seen within 4 enabled cycles → set err and restart FLUSH.
- IDLE:
  - busy=0.
  - start=1 → latch a and b, idx=0, go to LOAD.
- LOAD (1 cycle):
  - Drive shares of a[idx], b[idx] and r; and_enable=0.
  - Go to RUN with cyc=0.
- RUN (exactly 3 cycles):
  - and_enable=1; cyc increments each cycle; exit after cyc=2.
- CAPTURE (1 cycle):
  - and_enable=0. The gadget output is still valid this cycle and is zeroed by the gadget at the next edge.
  - If and_done=1: y[idx] <= and_out[0]^and_out[1].
  - Else: set err, discard the bit, go to FLUSH, then retry the same idx via LOAD.
  - On success: idx==N-1 → DONE, else idx++ → LOAD.
- DONE (1 cycle): done=1, then IDLE.
- Throughput: 5 cycles per bit; start-to-done = 5N+1 cycles, with no FLUSH retries.
- start while busy: ignored, no queueing.
- Async rst mid-operation: everything returns to reset values immediately. The gadget counter may be left at 1 or 2, which the post-reset FLUSH realigns.
- Unmasked a_i/b_i never appear on any gadget port; only shares are driven.

Decomposition:
- Shared package: gadget share count D=2, gadget enabled latency (3), LFSR width, tap constant, and the state enum (FLUSH, IDLE, LOAD, RUN, CAPTURE, DONE).
- One sub-module: mask_lfsr16 (clk, rst, seed parameter, 16-bit state out).

Test Plan:
- Reset, then hold start=0 with a behavioural gadget model whose counter is preset to 2 → FLUSH ends in IDLE after ≤2 enabled cycles; busy falls; err=0.
- a=8'hF0, b=8'h3C, start pulse → done at start+41 cycles, y=8'h30; and_enable high exactly 3 cycles per bit, 8 times.
- a=8'hFF, b=8'hFF → y=8'hFF. Then a=8'h00, b=8'hA5 → y=8'h00. Check and_ina[0]^and_ina[1]==a_i on every LOAD, and that and_ina[1] varies across bits.
- Model gadget withholds and_done in CAPTURE for bit 3 → err=1 (sticky), FLUSH, bit 3 retried; final y still correct; done delayed by the flush length.
- rst asserted mid-RUN of bit 4 → all outputs reset asynchronously; after release, FLUSH realigns; a fresh start (a=8'h55, b=8'h0F) gives y=8'h05.
- start held high during busy and re-pulsed in DONE → neither accepted; only a start sampled in IDLE launches the next operation.
